// File: rtl/seg_scan_capture.sv
`timescale 1ns/1ps
// Receive-side monitor for a multiplexed 7-segment scan bus: settles each lit slot, decodes it to BCD+dp
// and publishes coherent 8-digit frames. Define SEG_SCAN_TIMEOUT_EN to add the scan-stall watchdog.
module seg_scan_capture #(
   parameter int SETTLE           = 4,
   parameter bit DIGIT_ACTIVE_LOW = 1'b0,
   parameter int TIMEOUT          = 100000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  digit,
   input  logic [7:0]  seg_data,
   output logic [31:0] digits_bcd,
   output logic [7:0]  dp_out,
   output logic        frame_valid,
   output logic        scan_err,
   output logic        pattern_err,
   output logic        stalled
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_SETTLE  = 2'd1;
   localparam logic [1:0] ST_CAPTURE = 2'd2;
   localparam logic [1:0] ST_HOLD    = 2'd3;
   localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

   if (SETTLE < 1 || SETTLE > 15 || TIMEOUT < 1) begin : g_param_check
      $error("seg_scan_capture: SETTLE must be 1..15 and TIMEOUT positive");
   end

   function automatic logic [3:0] seg_decode(input logic [6:0] s);
      case (s)
         7'h7E:   seg_decode = 4'h0;
         7'h30:   seg_decode = 4'h1;
         7'h6D:   seg_decode = 4'h2;
         7'h79:   seg_decode = 4'h3;
         7'h33:   seg_decode = 4'h4;
         7'h5B:   seg_decode = 4'h5;
         7'h5F:   seg_decode = 4'h6;
         7'h70:   seg_decode = 4'h7;
         7'h7F:   seg_decode = 4'h8;
         7'h7B:   seg_decode = 4'h9;
         7'h00:   seg_decode = 4'hF;
         default: seg_decode = 4'hE;
      endcase
   endfunction

   logic [7:0]  dig_s1_q, dig_s2_q, seg_s1_q, seg_s2_q;
   logic [1:0]  state_q, state_d;
   logic [7:0]  held_dig_q, held_dig_d, held_seg_q, held_seg_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [7:0]  mask_q, mask_d;
   logic        frame_pend_q, frame_pend_d;
   logic        scan_err_q, scan_err_d;
   logic        pattern_err_q, frame_valid_q;
   logic [31:0] digits_bcd_q, shadow_bcd;
   logic [7:0]  dp_q, shadow_dp;
   logic [7:0]  dig_sync;
   logic [3:0]  code;
   logic        one_hot, same, capture;

   assign dig_sync = DIGIT_ACTIVE_LOW ? ~dig_s2_q : dig_s2_q;
   assign one_hot  = (dig_sync != 8'h00) && ((dig_sync & (dig_sync - 8'd1)) == 8'h00);
   assign same     = (dig_sync == held_dig_q) && (seg_s2_q == held_seg_q);
   assign capture  = (state_q == ST_CAPTURE);
   assign code     = seg_decode(held_seg_q[7:1]);

   always_comb begin
      state_d    = state_q;
      held_dig_d = held_dig_q;
      held_seg_d = held_seg_q;
      cnt_d      = cnt_q;
      scan_err_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (one_hot) begin
               state_d    = ST_SETTLE;
               held_dig_d = dig_sync;
               held_seg_d = seg_s2_q;
               cnt_d      = 4'd1;
            end else if (dig_sync != 8'h00) begin
               scan_err_d = 1'b1;
            end
         end
         ST_SETTLE: begin
            if (cnt_q >= SETTLE_CNT) state_d = ST_CAPTURE;
            else if (same)           cnt_d   = cnt_q + 4'd1;
            else                     state_d = ST_IDLE;
         end
         ST_CAPTURE: state_d = ST_HOLD;
         default: begin
            // A static slot is captured once; only a change re-arms the search.
            if (!same) state_d = ST_IDLE;
         end
      endcase
   end

   // The copy cycle always lands in HOLD, so clearing the mask never races a capture.
   assign mask_d       = frame_pend_q ? 8'h00 : (capture ? (mask_q | held_dig_q) : mask_q);
   assign frame_pend_d = capture && ((mask_q | held_dig_q) == 8'hFF);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dig_s1_q      <= 8'h00;
         dig_s2_q      <= 8'h00;
         seg_s1_q      <= 8'h00;
         seg_s2_q      <= 8'h00;
         state_q       <= ST_IDLE;
         held_dig_q    <= 8'h00;
         held_seg_q    <= 8'h00;
         cnt_q         <= 4'd0;
         mask_q        <= 8'h00;
         frame_pend_q  <= 1'b0;
         scan_err_q    <= 1'b0;
         pattern_err_q <= 1'b0;
         frame_valid_q <= 1'b0;
         digits_bcd_q  <= 32'hFFFF_FFFF;
         dp_q          <= 8'h00;
      end else begin
         dig_s1_q      <= digit;
         dig_s2_q      <= dig_s1_q;
         seg_s1_q      <= seg_data;
         seg_s2_q      <= seg_s1_q;
         state_q       <= state_d;
         held_dig_q    <= held_dig_d;
         held_seg_q    <= held_seg_d;
         cnt_q         <= cnt_d;
         mask_q        <= mask_d;
         frame_pend_q  <= frame_pend_d;
         scan_err_q    <= scan_err_d;
         frame_valid_q <= frame_pend_q;
         if (capture && code == 4'hE) pattern_err_q <= 1'b1;
         if (frame_pend_q) begin
            digits_bcd_q <= shadow_bcd;
            dp_q         <= shadow_dp;
         end
      end
   end

   for (genvar gi = 0; gi < 8; gi++) begin : g_slot
      logic [3:0] nib_q;
      logic       dp_slot_q;
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            nib_q     <= 4'hF;
            dp_slot_q <= 1'b0;
         end else if (capture && held_dig_q[gi]) begin
            nib_q     <= code;
            dp_slot_q <= held_seg_q[0];
         end
      end
      assign shadow_bcd[gi*4 +: 4] = nib_q;
      assign shadow_dp[gi]         = dp_slot_q;
   end

`ifdef SEG_SCAN_TIMEOUT_EN
   localparam int WD_W = ($clog2(TIMEOUT + 1) > 17) ? $clog2(TIMEOUT + 1) : 17;
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);
   logic [WD_W-1:0] wdog_q;
   logic            stalled_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wdog_q    <= '0;
         stalled_q <= 1'b0;
      end else if (capture) begin
         wdog_q    <= '0;
         stalled_q <= 1'b0;
      end else if (wdog_q != WD_MAX) begin
         wdog_q <= wdog_q + 1'b1;
         if (wdog_q + 1'b1 == WD_MAX) stalled_q <= 1'b1;
      end
   end
   assign stalled = stalled_q;
`else
   assign stalled = 1'b0;
`endif

   assign digits_bcd  = digits_bcd_q;
   assign dp_out      = dp_q;
   assign frame_valid = frame_valid_q;
   assign scan_err    = scan_err_q;
   assign pattern_err = pattern_err_q;

endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Receive-side counterpart of the multiplexed 7-segment display driver.
- Samples the scanned digit-select and segment bus (digit[7:0], seg_data[7:0] = {a,b,c,d,e,f,g,dp}).
- Decodes each lit position back to a BCD code plus decimal point, and presents a coherent 8-digit frame.
- Used as an on-chip display monitor / loopback checker and as a bus reader on boards that receive the scan lines.

Parameters:
- SETTLE, 4: consecutive identical synchronized samples required before a digit is captured (anti-ghosting); range 1..15.
- DIGIT_ACTIVE_LOW, 0: 1 = a digit-select line is active when 0.
- TIMEOUT, 100000: cycles without a new capture before stall is flagged (used only with the optional feature).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- digit  in  8  scanned digit-select lines, one-hot per scan slot
- seg_data  in  8  {a,b,c,d,e,f,g,dp}, segment active-high (1 = lit)
- digits_bcd  out  32  nibble k = decoded code of position k (position 0 in bits [3:0])
- dp_out  out  8  bit k = decimal point of position k
- frame_valid  out  1  one-cycle pulse when digits_bcd/dp_out update
- scan_err  out  1  one-cycle pulse on a multi-hot digit sample
- pattern_err  out  1  sticky; set on an undecodable segment pattern
- stalled  out  1  scan-timeout flag

Behaviour:
- Reset (reset=0):
  - All outputs 0; digits_bcd = 32'hFFFF_FFFF (all blank).
  - Internal shadow registers blank; captured-mask 0; FSM in IDLE.
- Input conditioning:
  - digit and seg_data pass through a 2-flop synchronizer.
  - digit is inverted when DIGIT_ACTIVE_LOW=1.
  - Capture latency from the input pin is therefore at least 2+SETTLE cycles.
- Decode, with seg[6:0] = {a..g}:
  - 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7, 7F→8, 7B→9.
  - 00 → 4'hF (blank).
  - Anything else → 4'hE, and pattern_err is set.
  - dp is stored raw.
- FSM:
  - IDLE:
    - Synchronized digit == 0 → stay in IDLE.
    - Exactly one bit set → SETTLE: load the sample, counter=1.
    - More than one bit set → pulse scan_err, stay in IDLE.
  - SETTLE:
    - Sample identical to the held one (digit and seg) → counter++.
    - Sample differs → return to IDLE (nothing captured; re-evaluated next cycle).
    - counter == SETTLE → CAPTURE.
  - CAPTURE (1 cycle):
    - Write the decoded nibble and dp into shadow position k; set mask[k].
    - Go to HOLD.
  - HOLD:
    - Stay while the sample is unchanged.
    - Any change → IDLE (no re-capture of a static slot).
- Frame completion:
  - When mask becomes 8'hFF in a CAPTURE cycle:
    - Next cycle, shadow is copied to digits_bcd/dp_out and frame_valid pulses 1 cycle.
    - mask clears in the same cycle the copy is made.
  - A position recaptured before the frame completes overwrites its shadow entry; the last value wins.
- Simultaneous events:
  - The capture that completes the frame and a multi-hot sample on the following cycle are independent: both frame_valid and scan_err may pulse.
- Reset mid-operation:
  - Takes effect immediately, including a partial frame (mask cleared, shadow blanked).
- pattern_err is cleared only by reset.

Optional Feature:
- Macro SEG_SCAN_TIMEOUT_EN.
- Defined:
  - 17+ bit watchdog counts cycles since the last CAPTURE.
  - Reaching TIMEOUT sets stalled and saturates the counter.
  - The next CAPTURE clears stalled and the counter.
  - digits_bcd and dp_out retain their last frame.
- Undefined:
  - No counter is instantiated; stalled is tied 0.

Test Plan:
- Scan 8 positions, each held 10 cycles: position k shows BCD k (k=0..7), dp only on position 2, SETTLE=4 → exactly one frame_valid; digits_bcd=32'h7654_3210; dp_out=8'h04; no error pulses.
- Hold a position for 3 cycles only (SETTLE=4), then move on → that slot is not captured; no frame_valid until the slot is rescanned for ≥4 cycles.
- digit=8'h05 for 1 cycle → scan_err pulses once; mask unchanged; a subsequent clean scan still completes the frame.
- seg pattern 7'h01 on position 3 → pattern_err=1 (sticky); nibble 3 = E after the frame.
- Blank segments on position 7 → nibble 7 = F.
- Assert reset mid-frame after 5 positions → outputs return to their reset values; a full 8-position scan is needed before frame_valid.
- With SEG_SCAN_TIMEOUT_EN and TIMEOUT=50: stop the scan → stalled=1 at cycle 50 after the last capture; resume → stalled=0 on the first capture. Without the macro → stalled stays 0.
